lc4_mem_arbiter: RTL

- Shares one single-port, synchronous-read unified memory between three requesters: LC4 instruction fetch (I), LC4 data access (D) and the RS232 program loader (L).
- Sits between lc4_processor, the UART loader and the memory block RAM.
- Grants at most one access per cycle and returns read data exactly one cycle after the grant.
- Bounds the loader's priority so the processor is never starved.

---
 rtl/lc4_mem_pkg.sv | 20 ++
 rtl/lc4_rr2.sv | 27 ++
 rtl/lc4_mem_arbiter.sv | 102 ++++++++++
 3 files changed

// File: rtl/lc4_mem_pkg.sv
// Shared types for the LC4 unified-memory arbiter: owner tags, round-robin
// encoding and default widths.
package lc4_mem_pkg;
    localparam int WORD_SIZE_DEF    = 16;
    localparam int ADDR_WIDTH_DEF   = 16;
    localparam int STARVE_LIMIT_DEF = 4;
    localparam int STREAK_W         = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_L    = 2'd1,
        OWN_I    = 2'd2,
        OWN_D    = 2'd3
    } owner_e;

    typedef enum logic {
        RR_I = 1'b0,
        RR_D = 1'b1
    } rr_e;
endpackage

// File: rtl/lc4_rr2.sv
// Two-way round-robin picker between instruction fetch and data access.
// The requester that was not served last wins a tie.
module lc4_rr2
    import lc4_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_req_i,
    input  logic i_req_d,
    output logic o_gnt_i,
    output logic o_gnt_d
);
    rr_e r_last;

    always_comb begin
        o_gnt_i = i_en & i_req_i & (~i_req_d | (r_last == RR_D));
        o_gnt_d = i_en & i_req_d & (~i_req_i | (r_last == RR_I));
    end

    // Reset to D so fetch wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         r_last <= RR_D;
        else if (o_gnt_i) r_last <= RR_I;
        else if (o_gnt_d) r_last <= RR_D;
    end
endmodule

// File: rtl/lc4_mem_arbiter.sv
// Arbitrates one synchronous-read memory between loader, fetch and data ports,
// with loader priority bounded by a starvation counter and a 1-cycle read return.
module lc4_mem_arbiter
    import lc4_mem_pkg::*;
#(
    parameter int WORD_SIZE    = WORD_SIZE_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  l_req,
    input  logic                  l_we,
    input  logic [ADDR_WIDTH-1:0] l_addr,
    input  logic [WORD_SIZE-1:0]  l_wdata,
    output logic                  l_gnt,
    output logic                  l_rvalid,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_gnt,
    output logic                  i_rvalid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [WORD_SIZE-1:0]  d_wdata,
    output logic                  d_gnt,
    output logic                  d_rvalid,
    output logic [WORD_SIZE-1:0]  rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WORD_SIZE-1:0]  mem_wdata,
    input  logic [WORD_SIZE-1:0]  mem_rdata
);
    localparam logic [STREAK_W-1:0] LIMIT = STREAK_W'(STARVE_LIMIT);

    logic [STREAK_W-1:0] r_streak;
    owner_e              r_own;
    owner_e              w_rd_own;
    logic                w_id_req;
    logic                w_l_win;
    logic                w_i_gnt;
    logic                w_d_gnt;

    // Loader loses priority only once it has used up its streak while I/D wait.
    assign w_id_req = i_req | d_req;
    assign w_l_win  = rst & l_req & ~((r_streak == LIMIT) & w_id_req);

    lc4_rr2 u_rr2 (
        .clk     (clk),
        .rst     (rst),
        .i_en    (rst & ~w_l_win),
        .i_req_i (i_req),
        .i_req_d (d_req),
        .o_gnt_i (w_i_gnt),
        .o_gnt_d (w_d_gnt)
    );

    assign l_gnt = w_l_win;
    assign i_gnt = w_i_gnt;
    assign d_gnt = w_d_gnt;

    always_comb begin
        mem_en    = w_l_win | w_i_gnt | w_d_gnt;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_rd_own  = OWN_NONE;
        if (w_l_win) begin
            mem_we    = l_we;
            mem_addr  = l_addr;
            mem_wdata = l_wdata;
            w_rd_own  = l_we ? OWN_NONE : OWN_L;
        end else if (w_i_gnt) begin
            mem_addr  = i_addr;
            w_rd_own  = OWN_I;
        end else if (w_d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            w_rd_own  = d_we ? OWN_NONE : OWN_D;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_streak <= '0;
            r_own    <= OWN_NONE;
        end else begin
            r_own <= w_rd_own;
            if (w_i_gnt | w_d_gnt | ~w_id_req)
                r_streak <= '0;
            else if (w_l_win && r_streak != LIMIT)
                r_streak <= r_streak + 1'b1;
        end
    end

    assign l_rvalid = (r_own == OWN_L);
    assign i_rvalid = (r_own == OWN_I);
    assign d_rvalid = (r_own == OWN_D);
    assign rdata    = mem_rdata;
endmodule
